// File: rtl/vedic_mac_pipe.sv
// vedic_mac_pipe: three-stage pipelined multiply-accumulate unit.
//   stage 1 : four half-width Vedic quadrant products are registered
//   stage 2 : quadrant products are combined into the exact 2*WIDTH product
//   stage 3 : product is accumulated per packet; a last beat emits the result
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The
// whole pipeline advances only when the output register is free or being
// drained (adv = !out_valid || out_ready), so in_ready equals adv and every
// stage, valid bits included, holds while a result waits for out_ready.

// 2x2 Vedic cell: vertical and crosswise partial products of two 2-bit values.
module vedic_cell2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   logic cross_lo;
   logic cross_hi;
   logic carry;
   logic top;

   // Crosswise term plus its carry into the vertical high term.
   always_comb begin
      cross_lo = a[1] & b[0];
      cross_hi = a[0] & b[1];
      carry    = cross_lo & cross_hi;
      top      = a[1] & b[1];
      p[0]     = a[0] & b[0];
      p[1]     = cross_lo ^ cross_hi;
      p[2]     = top ^ carry;
      p[3]     = top & carry;
   end
endmodule

// Recursive Vedic multiplier: splits N-bit operands into halves until the
// 2x2 cell is reached, then recombines the four partial products.
module vedic_mul #(
   parameter int N = 4
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);
   generate
      if (N == 2) begin : g_leaf
         vedic_cell2 u_cell (.a(a), .b(b), .p(p));
      end else begin : g_split
         localparam int H = N / 2;
         logic [N-1:0] pp0;
         logic [N-1:0] pp1;
         logic [N-1:0] pp2;
         logic [N-1:0] pp3;

         vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pp0));
         vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(pp1));
         vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(pp2));
         vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(pp3));

         // Shift-and-add of the quadrant products into the full product.
         always_comb begin
            p = {{N{1'b0}}, pp0}
              + {{H{1'b0}}, pp1, {H{1'b0}}}
              + {{H{1'b0}}, pp2, {H{1'b0}}}
              + {pp3, {N{1'b0}}};
         end
      end
   endgenerate
endmodule

module vedic_mac_pipe #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 24,
   parameter int CNT_WIDTH = 8,
   parameter int SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_ovf
);
   localparam int H    = WIDTH / 2;
   localparam int PW   = 2 * WIDTH;
   localparam int EXTW = ACC_WIDTH + 1 - PW;

   logic adv;
   logic accept;

   // Quadrant products from the combinational half-width multipliers.
   logic [WIDTH-1:0] q0_c;
   logic [WIDTH-1:0] q1_c;
   logic [WIDTH-1:0] q2_c;
   logic [WIDTH-1:0] q3_c;

   // Stage 1 registers.
   logic             s1_valid;
   logic             s1_first;
   logic             s1_last;
   logic [WIDTH-1:0] s1_q0;
   logic [WIDTH-1:0] s1_q1;
   logic [WIDTH-1:0] s1_q2;
   logic [WIDTH-1:0] s1_q3;

   // Stage 2 registers.
   logic          s2_valid;
   logic          s2_first;
   logic          s2_last;
   logic [PW-1:0] s2_prod;
   logic [PW-1:0] prod_c;

   // Accumulator state for the packet in progress.
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ovf;

   // Next-state values of the accumulator stage.
   logic [ACC_WIDTH-1:0] base;
   logic [ACC_WIDTH:0]   sum;
   logic                 ovf_now;
   logic [ACC_WIDTH-1:0] acc_next;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 ovf_next;

   // Flow control: the pipeline moves whenever the output slot can take a result.
   always_comb begin
      adv      = !out_valid || out_ready;
      in_ready = adv;
      accept   = in_valid && adv;
   end

   vedic_mul #(.N(H)) u_q0 (.a(in_a[H-1:0]),     .b(in_b[H-1:0]),     .p(q0_c));
   vedic_mul #(.N(H)) u_q1 (.a(in_a[H-1:0]),     .b(in_b[WIDTH-1:H]), .p(q1_c));
   vedic_mul #(.N(H)) u_q2 (.a(in_a[WIDTH-1:H]), .b(in_b[H-1:0]),     .p(q2_c));
   vedic_mul #(.N(H)) u_q3 (.a(in_a[WIDTH-1:H]), .b(in_b[WIDTH-1:H]), .p(q3_c));

   // Stage 1: capture quadrant products and the packet flags of the accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_q0    <= '0;
         s1_q1    <= '0;
         s1_q2    <= '0;
         s1_q3    <= '0;
      end else if (adv) begin
         s1_valid <= accept;
         s1_first <= in_first;
         s1_last  <= in_last;
         s1_q0    <= q0_c;
         s1_q1    <= q1_c;
         s1_q2    <= q2_c;
         s1_q3    <= q3_c;
      end
   end

   // Recombine the registered quadrants: q0 + (q1+q2)<<H + q3<<2H.
   always_comb begin
      prod_c = {{WIDTH{1'b0}}, s1_q0}
             + {{H{1'b0}}, s1_q1, {H{1'b0}}}
             + {{H{1'b0}}, s1_q2, {H{1'b0}}}
             + {s1_q3, {WIDTH{1'b0}}};
   end

   // Stage 2: register the exact product alongside its flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_prod  <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_prod  <= prod_c;
      end
   end

   // Accumulate with one spare bit so the carry out marks a wrap or clamp.
   always_comb begin
      base     = s2_first ? '0 : acc;
      sum      = {1'b0, base} + {{EXTW{1'b0}}, s2_prod};
      ovf_now  = sum[ACC_WIDTH];
      acc_next = sum[ACC_WIDTH-1:0];
      if ((SATURATE != 0) && ovf_now) begin
         acc_next = '1;
      end
      cnt_next = s2_first ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt + 1'b1;
      ovf_next = (s2_first ? 1'b0 : ovf) | ovf_now;
   end

   // Stage 3: running packet state; a last beat hands off and clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (adv && s2_valid) begin
         if (s2_last) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
         end
      end
   end

   // Output slot: load on a completing last beat, otherwise empty once drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (adv) begin
         if (s2_valid && s2_last) begin
            out_valid <= 1'b1;
            out_acc   <= acc_next;
            out_count <= cnt_next;
            out_ovf   <= ovf_next;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Bench for vedic_mac_pipe: three instances (24-bit wrap, 16-bit wrap,
// 16-bit saturate) share one stimulus stream; a packet-level model predicts
// each result and when it becomes visible.
module tb_vedic_mac_pipe;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_first;
   logic       in_last;
   logic       out_ready;

   logic        in_ready_a, in_ready_w, in_ready_s;
   logic        out_valid_a, out_valid_w, out_valid_s;
   logic [23:0] out_acc_a;
   logic [15:0] out_acc_w, out_acc_s;
   logic [7:0]  out_count_a, out_count_w, out_count_s;
   logic        out_ovf_a, out_ovf_w, out_ovf_s;

   vedic_mac_pipe #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8), .SATURATE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
      .out_count(out_count_a), .out_ovf(out_ovf_a));

   vedic_mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_acc(out_acc_w),
      .out_count(out_count_w), .out_ovf(out_ovf_w));

   vedic_mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_acc(out_acc_s),
      .out_count(out_count_s), .out_ovf(out_ovf_s));

   // Clock and reset block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: one entry per completed packet, with the advance count at
   // which its result must appear.
   typedef struct {
      int     due;
      longint acc_a;
      longint acc_w;
      longint acc_s;
      int     cnt;
      bit     ovf_a;
      bit     ovf_w;
      bit     ovf_s;
   } exp_t;
   exp_t exp_q[$];

   longint m_acc_a, m_acc_w, m_acc_s;
   int     m_cnt;
   bit     m_ovf_a, m_ovf_w, m_ovf_s;
   int     adv_cnt = 0;
   int     pk = 0;
   bit     exp_valid, exp_ready;

   // Hand-computed per-packet results, in stimulus order.
   int lit_acc_a[11] = '{65025, 65246, 65246, 6, 130050, 1, 130051, 20, 53, 9, 25};
   int lit_acc_w[11] = '{65025, 65246, 65246, 6, 64514, 1, 64515, 20, 53, 9, 25};
   int lit_acc_s[11] = '{65025, 65246, 65246, 6, 65535, 1, 65535, 20, 53, 9, 25};
   int lit_cnt[11]   = '{1, 3, 3, 1, 2, 1, 3, 1, 2, 1, 1};
   int lit_ovf_w[11] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

   task automatic model_clear();
      m_acc_a = 0; m_acc_w = 0; m_acc_s = 0; m_cnt = 0;
      m_ovf_a = 0; m_ovf_w = 0; m_ovf_s = 0;
   endtask

   // Packet arithmetic in plain integers: wrap by modulo, clamp by compare.
   task automatic model_beat(input longint a, input longint b, input bit f, input bit l);
      longint prod, sa, sw, ss;
      exp_t e;
      prod = a * b;
      sa = (f ? 0 : m_acc_a) + prod;
      sw = (f ? 0 : m_acc_w) + prod;
      ss = (f ? 0 : m_acc_s) + prod;
      m_ovf_a = (f ? 1'b0 : m_ovf_a) | (sa >= 64'd16777216);
      m_ovf_w = (f ? 1'b0 : m_ovf_w) | (sw >= 64'd65536);
      m_ovf_s = (f ? 1'b0 : m_ovf_s) | (ss >= 64'd65536);
      m_acc_a = sa % 64'd16777216;
      m_acc_w = sw % 64'd65536;
      m_acc_s = (ss >= 64'd65536) ? 64'd65535 : ss;
      m_cnt   = f ? 1 : (m_cnt + 1) % 256;
      if (l) begin
         e.due = adv_cnt + 2;
         e.acc_a = m_acc_a; e.acc_w = m_acc_w; e.acc_s = m_acc_s;
         e.cnt = m_cnt; e.ovf_a = m_ovf_a; e.ovf_w = m_ovf_w; e.ovf_s = m_ovf_s;
         if (pk < 11) begin
            chk("lit_acc_a", e.acc_a, lit_acc_a[pk]);
            chk("lit_acc_w", e.acc_w, lit_acc_w[pk]);
            chk("lit_acc_s", e.acc_s, lit_acc_s[pk]);
            chk("lit_cnt", e.cnt, lit_cnt[pk]);
            chk("lit_ovf_a", e.ovf_a, 0);
            chk("lit_ovf_w", e.ovf_w, lit_ovf_w[pk]);
            chk("lit_ovf_s", e.ovf_s, lit_ovf_w[pk]);
         end
         pk++;
         exp_q.push_back(e);
         model_clear();
      end
   endtask

   // Compare process: inputs settle 1ns after each rising edge, so on the
   // falling edge both DUT outputs and the upcoming edge's inputs are stable.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid_a", out_valid_a, 0);
         chk("rst_out_valid_w", out_valid_w, 0);
         chk("rst_out_valid_s", out_valid_s, 0);
         chk("rst_out_acc_a", out_acc_a, 0);
         chk("rst_out_count_a", out_count_a, 0);
         chk("rst_out_ovf_a", out_ovf_a, 0);
         exp_q.delete();
         model_clear();
      end else begin
         exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= adv_cnt);
         exp_ready = !exp_valid || out_ready;
         chk("in_ready_a", in_ready_a, exp_ready);
         chk("in_ready_w", in_ready_w, exp_ready);
         chk("in_ready_s", in_ready_s, exp_ready);
         chk("out_valid_a", out_valid_a, exp_valid);
         chk("out_valid_w", out_valid_w, exp_valid);
         chk("out_valid_s", out_valid_s, exp_valid);
         if (exp_valid) begin
            chk("out_acc_a", out_acc_a, exp_q[0].acc_a);
            chk("out_acc_w", out_acc_w, exp_q[0].acc_w);
            chk("out_acc_s", out_acc_s, exp_q[0].acc_s);
            chk("out_count_a", out_count_a, exp_q[0].cnt);
            chk("out_count_w", out_count_w, exp_q[0].cnt);
            chk("out_count_s", out_count_s, exp_q[0].cnt);
            chk("out_ovf_a", out_ovf_a, exp_q[0].ovf_a);
            chk("out_ovf_w", out_ovf_w, exp_q[0].ovf_w);
            chk("out_ovf_s", out_ovf_s, exp_q[0].ovf_s);
            if (out_ready) void'(exp_q.pop_front());
         end
         if (exp_ready) begin
            adv_cnt++;
            if (in_valid) model_beat(in_a, in_b, in_first, in_last);
         end
      end
   end

   // Driver tasks.
   task automatic wait_accept();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready_a) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic send(input int a, input int b, input bit f, input bit l);
      in_a = 8'(a); in_b = 8'(b); in_first = f; in_last = l; in_valid = 1'b1;
      wait_accept();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_out_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_valid_a) seen = 1'b1;
      end
      if (!seen) chk("out_valid_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      // Single-beat packet, largest operands.
      send(255, 255, 1, 1);
      idle(4);

      // Three back-to-back beats.
      send(10, 20, 1, 0);
      send(3, 7, 0, 0);
      send(255, 255, 0, 1);
      idle(4);

      // Same packet held by backpressure while another beat is offered.
      out_ready = 1'b0;
      send(10, 20, 1, 0);
      send(3, 7, 0, 0);
      send(255, 255, 0, 1);
      in_valid = 1'b0;
      wait_out_valid();
      in_a = 8'd2; in_b = 8'd3; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_accept();
      idle(4);

      // Overflow within a packet, then a clean packet.
      send(255, 255, 1, 0);
      send(255, 255, 0, 1);
      send(1, 1, 1, 1);
      idle(4);

      // Clamp persists once saturated.
      send(255, 255, 1, 0);
      send(255, 255, 0, 0);
      send(1, 1, 0, 1);
      idle(4);

      // Reset mid-packet discards the partial sum.
      send(100, 100, 1, 0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(4, 5, 0, 1);
      idle(4);

      // Bubble, then a restart mid-packet.
      send(9, 9, 1, 0);
      idle(1);
      send(7, 7, 1, 0);
      send(2, 2, 0, 1);
      idle(4);

      // A beat without first after a last starts from zero.
      send(3, 3, 1, 1);
      send(5, 5, 0, 1);
      idle(4);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
      chk("drain", exp_q.size(), 0);
      chk("packet_count", pk, 11);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/vedic_mac_pipe.md
Name: vedic_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit and successor to the fixed 8-bit combinational Vedic multiplier. Splits each operand into halves, registers the four quadrant products, then combines them into the full product. Accumulates products over a packet delimited by first/last flags and returns the result over a valid/ready handshake with backpressure. Sits between an operand-streaming front end and the result collector in the MAC datapath.

Parameters:
WIDTH, 8, operand width in bits; power of 2, >= 4.
ACC_WIDTH, 24, accumulator/result width; must be >= 2*WIDTH.
CNT_WIDTH, 8, width of the per-packet beat counter.
SATURATE, 0, 0 = accumulator wraps mod 2^ACC_WIDTH; 1 = accumulator clamps at all-ones.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  unit can accept a beat.
in_a  in  WIDTH  unsigned multiplicand.
in_b  in  WIDTH  unsigned multiplier.
in_first  in  1  beat starts a new packet; accumulator base is 0, not the running sum.
in_last  in  1  beat ends the packet; result is emitted.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_acc  out  ACC_WIDTH  accumulated sum of products for the packet.
out_count  out  CNT_WIDTH  number of beats in the packet, wrapping mod 2^CNT_WIDTH.
out_ovf  out  1  overflow (wrap or clamp) occurred at least once in the packet.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, accumulator 0, count 0, sticky ovf 0. Outputs: out_valid=0, out_acc=0, out_count=0, out_ovf=0. in_ready=1 one cycle after release.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. When adv=0, every pipeline register, including the valid bits, holds.
- Stage 1 (edge k, accept = in_valid && in_ready):
  - Register q0=aL*bL, q1=aL*bH, q2=aH*bL, q3=aH*bH, each WIDTH bits. Halves are WIDTH/2 bits.
  - Quadrant multipliers use recursive Vedic decomposition down to 2x2 cells.
  - first/last travel with the data. s1_valid = accept.
- Stage 2 (edge k+1):
  - prod = q0 + (q1<<H) + (q2<<H) + (q3<<2H), with H=WIDTH/2. Result is 2*WIDTH bits, exact.
- Stage 3 (edge k+2), if s2_valid:
  - base = first ? 0 : acc.
  - sum = base + zero-extended prod, computed at ACC_WIDTH+1 bits. ovf_now = sum[ACC_WIDTH].
  - SATURATE=0: acc = sum mod 2^ACC_WIDTH. SATURATE=1: acc = ovf_now ? all-ones : sum. When acc is already all-ones and saturated, it stays all-ones.
  - Count: cnt = first ? 1 : cnt+1, wrapping. Sticky: ovf = (first ? 0 : ovf) | ovf_now.
  - If last: load out_acc/out_count/out_ovf with the new values and set out_valid=1. The internal acc, cnt and ovf clear to 0 on the same edge.
- Latency: a last beat accepted at edge k gives out_valid=1 from edge k+2. With no stalls the unit accepts 1 beat/cycle.
- Output handshake: out_valid && out_ready at an edge transfers the result. out_valid falls unless another last beat completes on the same edge; in that case the new result loads and out_valid stays 1.
- Output stability: while out_valid && !out_ready, the out_* signals are stable and in_ready=0.
- Packet boundaries:
  - A beat with first=1 and last=1 is a one-beat packet.
  - A beat with first=0 after a last continues from a zero accumulator.
  - A first=1 beat mid-packet discards the partial sum.
- Bubbles (in_valid=0) propagate as invalid stages. They leave acc and cnt unchanged.
- Reset mid-packet: all partial state and any pending result are lost. No output is produced for the aborted packet.

Test Plan:
1. WIDTH=8, ACC_WIDTH=24, single beat a=255, b=255, first=last=1, out_ready=1 -> out_acc=65025, out_count=1, out_ovf=0; out_valid from edge k+2, high for 1 cycle.
2. Three back-to-back beats (10,20,first), (3,7), (255,255,last) -> out_acc=65246, out_count=3, out_ovf=0; in_ready held 1 throughout.
3. Same packet as scenario 2 with out_ready=0 for 5 cycles after out_valid rises -> out_acc held at 65246, in_ready=0, offered beats not accepted; after out_ready=1 the next packet (2,3,first,last) yields out_acc=6.
4. ACC_WIDTH=16, SATURATE=0, beats (255,255,first), (255,255,last) -> out_acc=64514, out_ovf=1; then packet (1,1,first,last) -> out_acc=1, out_ovf=0.
5. ACC_WIDTH=16, SATURATE=1, same two beats followed by (1,1,last) in place of the last -> out_acc=65535, out_count=3, out_ovf=1.
6. rst_n pulsed low for 1 cycle after (100,100,first) is accepted; then (4,5,last) -> out_acc=20, out_count=1, and no stale 10000 appears.
